// File: rtl/smi_target_pkg.sv
// Shared definitions for the SMI register target: opcodes, status codes,
// header field layout and the transaction FSM encoding.
package smi_target_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_ERR = 8'h01;

  localparam int HDR_CODE_LSB = 0;
  localparam int HDR_CODE_W   = 8;
  localparam int HDR_TAG_LSB  = 8;
  localparam int HDR_TAG_W    = 24;

  localparam logic [7:0] EOFC_MID  = 8'd0;
  localparam logic [7:0] EOFC_LAST = 8'd4;

  typedef logic [HDR_CODE_W-1:0] code_t;
  typedef logic [HDR_TAG_W-1:0]  tag_t;

  typedef enum logic [2:0] {
    S_HDR      = 3'd0,
    S_ADDR     = 3'd1,
    S_WDATA    = 3'd2,
    S_DRAIN    = 3'd3,
    S_RSP_HDR  = 3'd4,
    S_RSP_DATA = 3'd5
  } state_e;

  function automatic code_t hdr_code(input logic [31:0] flit);
    return flit[HDR_CODE_LSB +: HDR_CODE_W];
  endfunction

  function automatic tag_t hdr_tag(input logic [31:0] flit);
    return flit[HDR_TAG_LSB +: HDR_TAG_W];
  endfunction

  function automatic logic [31:0] pack_header(input tag_t tag, input code_t code);
    return {tag, code};
  endfunction

  function automatic logic op_valid(input code_t op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/smi_resp_out_reg.sv
// Response flit holding register: a loaded flit stays on the outputs,
// unchanged, until the sink accepts it (Ready=1 and Stop=0).
module smi_resp_out_reg (
  input  logic        clk,
  input  logic        srst,
  input  logic        load,
  input  logic [7:0]  load_eofc,
  input  logic [31:0] load_data,
  input  logic        stop,
  output logic        ready,
  output logic [7:0]  eofc,
  output logic [31:0] data,
  output logic        fire
);

  assign fire = ready && !stop;

  // Load has priority so a follow-on flit can replace one leaving this cycle
  always_ff @(posedge clk) begin
    if (srst) begin
      ready <= 1'b0;
      eofc  <= 8'd0;
      data  <= 32'd0;
    end else if (load) begin
      ready <= 1'b1;
      eofc  <= load_eofc;
      data  <= load_data;
    end else if (fire) begin
      ready <= 1'b0;
      eofc  <= 8'd0;
      data  <= 32'd0;
    end
  end

endmodule

// File: rtl/smi_register_target.sv
// SMI target endpoint: executes single-word read/write request frames against
// an internal register bank and returns tag-echoing response frames.
module smi_register_target
  import smi_target_pkg::*;
#(
  parameter int          RegAddrWidth = 4,
  parameter logic [31:0] ResetValue   = 32'h0
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic                               smiReqInReady,
  input  logic [7:0]                         smiReqInEofc,
  input  logic [31:0]                        smiReqInData,
  output logic                               smiReqInStop,
  output logic                               smiRespOutReady,
  output logic [7:0]                         smiRespOutEofc,
  output logic [31:0]                        smiRespOutData,
  input  logic                               smiRespOutStop,
  output logic [32*(2**RegAddrWidth)-1:0]    regBankOut,
  output logic                               regWrStrobe,
  output logic [RegAddrWidth-1:0]            regWrIndex
);

  localparam int NumRegs = 2**RegAddrWidth;

  state_e                  state_r;
  state_e                  state_next;
  tag_t                    tag_r;
  code_t                   op_r;
  logic [RegAddrWidth-1:0] idx_r;
  logic                    err_r;
  logic                    err_next;
  logic [31:0]             bank_r [NumRegs];
  logic                    wr_strobe_r;
  logic [RegAddrWidth-1:0] wr_index_r;

  logic        accepting_s;
  logic        req_fire_s;
  logic        resp_fire_s;
  logic        addr_bad_s;
  tag_t        cur_tag_s;
  code_t       cur_op_s;
  logic        resp_load_s;
  logic [7:0]  resp_load_eofc_s;
  logic [31:0] resp_load_data_s;
  logic        wr_commit_s;

  assign accepting_s = (state_r == S_HDR) || (state_r == S_ADDR) ||
                       (state_r == S_WDATA) || (state_r == S_DRAIN);
  assign smiReqInStop = srst || !accepting_s;
  assign req_fire_s   = smiReqInReady && !smiReqInStop;

  assign addr_bad_s = (smiReqInData[1:0] != 2'b00) ||
                      ((smiReqInData >> (RegAddrWidth + 2)) != 32'd0);

  // The header-cycle response must use the flit on the bus, not the latched copy
  assign cur_tag_s = (state_r == S_HDR) ? hdr_tag(smiReqInData)  : tag_r;
  assign cur_op_s  = (state_r == S_HDR) ? hdr_code(smiReqInData) : op_r;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_r <= S_HDR;
    end else begin
      state_r <= state_next;
    end
  end

  always_comb begin
    state_next = state_r;
    err_next   = err_r;
    case (state_r)
      S_HDR: begin
        if (req_fire_s) begin
          err_next = !op_valid(hdr_code(smiReqInData)) || (smiReqInEofc != EOFC_MID);
          if (smiReqInEofc != EOFC_MID) begin
            state_next = S_RSP_HDR;
          end else begin
            state_next = S_ADDR;
          end
        end else begin
          state_next = S_HDR;
        end
      end
      S_ADDR: begin
        if (req_fire_s) begin
          err_next = err_r || addr_bad_s;
          if ((op_r == OP_READ) && (smiReqInEofc == EOFC_LAST)) begin
            state_next = S_RSP_HDR;
          end else if ((op_r == OP_WRITE) && (smiReqInEofc == EOFC_MID)) begin
            state_next = S_WDATA;
          end else begin
            err_next   = 1'b1;
            state_next = (smiReqInEofc == EOFC_MID) ? S_DRAIN : S_RSP_HDR;
          end
        end else begin
          state_next = S_ADDR;
        end
      end
      S_WDATA: begin
        if (req_fire_s) begin
          if (smiReqInEofc == EOFC_LAST) begin
            state_next = S_RSP_HDR;
          end else if (smiReqInEofc == EOFC_MID) begin
            err_next   = 1'b1;
            state_next = S_DRAIN;
          end else begin
            err_next   = 1'b1;
            state_next = S_RSP_HDR;
          end
        end else begin
          state_next = S_WDATA;
        end
      end
      S_DRAIN: begin
        if (req_fire_s && (smiReqInEofc != EOFC_MID)) begin
          state_next = S_RSP_HDR;
        end else begin
          state_next = S_DRAIN;
        end
      end
      S_RSP_HDR: begin
        if (resp_fire_s) begin
          state_next = ((op_r == OP_READ) && !err_r) ? S_RSP_DATA : S_HDR;
        end else begin
          state_next = S_RSP_HDR;
        end
      end
      S_RSP_DATA: begin
        if (resp_fire_s) begin
          state_next = S_HDR;
        end else begin
          state_next = S_RSP_DATA;
        end
      end
      default: begin
        state_next = S_HDR;
        err_next   = 1'b0;
      end
    endcase
  end

  always_comb begin
    resp_load_s      = 1'b0;
    resp_load_eofc_s = EOFC_MID;
    resp_load_data_s = 32'd0;
    if (accepting_s && (state_next == S_RSP_HDR)) begin
      resp_load_s      = 1'b1;
      resp_load_data_s = pack_header(cur_tag_s, err_next ? ST_ERR : ST_OK);
      resp_load_eofc_s = ((cur_op_s == OP_READ) && !err_next) ? EOFC_MID : EOFC_LAST;
    end else if ((state_r == S_RSP_HDR) && (state_next == S_RSP_DATA)) begin
      resp_load_s      = 1'b1;
      resp_load_data_s = bank_r[idx_r];
      resp_load_eofc_s = EOFC_LAST;
    end else begin
      resp_load_s = 1'b0;
    end
    wr_commit_s = (state_r == S_WDATA) && req_fire_s &&
                  (smiReqInEofc == EOFC_LAST) && !err_r;
  end

  // Commit happens on the data-flit accept edge, so a stalled response cannot repeat it
  always_ff @(posedge clk) begin
    if (srst) begin
      tag_r       <= '0;
      op_r        <= 8'd0;
      idx_r       <= '0;
      err_r       <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_index_r  <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        bank_r[i] <= ResetValue;
      end
    end else begin
      err_r       <= err_next;
      wr_strobe_r <= wr_commit_s;
      if (req_fire_s && (state_r == S_HDR)) begin
        tag_r <= hdr_tag(smiReqInData);
        op_r  <= hdr_code(smiReqInData);
      end
      if (req_fire_s && (state_r == S_ADDR)) begin
        idx_r <= smiReqInData[RegAddrWidth+1:2];
      end
      if (wr_commit_s) begin
        bank_r[idx_r] <= smiReqInData;
        wr_index_r    <= idx_r;
      end
    end
  end

  assign regWrStrobe = wr_strobe_r;
  assign regWrIndex  = wr_index_r;

  for (genvar g = 0; g < NumRegs; g++) begin : g_bank_out
    assign regBankOut[32*g +: 32] = bank_r[g];
  end

  smi_resp_out_reg u_resp_out (
    .clk       (clk),
    .srst      (srst),
    .load      (resp_load_s),
    .load_eofc (resp_load_eofc_s),
    .load_data (resp_load_data_s),
    .stop      (smiRespOutStop),
    .ready     (smiRespOutReady),
    .eofc      (smiRespOutEofc),
    .data      (smiRespOutData),
    .fire      (resp_fire_s)
  );

endmodule

// File: tb/tb_smi_register_target.sv
// Directed, table-driven bench for smi_register_target with hand-written
// sequences for response stall and mid-frame reset.
module tb_smi_register_target;

  localparam int W = 4;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           srst;
  logic           req_ready;
  logic [7:0]     req_eofc;
  logic [31:0]    req_data;
  logic           req_stop;
  logic           resp_ready;
  logic [7:0]     resp_eofc;
  logic [31:0]    resp_data;
  logic           resp_stop;
  logic [32*N-1:0] bank;
  logic           wr_strobe;
  logic [W-1:0]   wr_index;

  always #5 clk = ~clk;

  smi_register_target #(.RegAddrWidth(W), .ResetValue(32'h0)) dut (
    .clk             (clk),
    .srst            (srst),
    .smiReqInReady   (req_ready),
    .smiReqInEofc    (req_eofc),
    .smiReqInData    (req_data),
    .smiReqInStop    (req_stop),
    .smiRespOutReady (resp_ready),
    .smiRespOutEofc  (resp_eofc),
    .smiRespOutData  (resp_data),
    .smiRespOutStop  (resp_stop),
    .regBankOut      (bank),
    .regWrStrobe     (wr_strobe),
    .regWrIndex      (wr_index)
  );

  typedef struct packed {
    logic [2:0]       nreq;
    logic [4:0][31:0] rq;
    logic [39:0]      re;
    logic [1:0]       nrsp;
    logic [1:0][31:0] rs;
    logic             wr;
    logic [3:0]       idx;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_regs [N];
  vec_t        vecs [15];

  function automatic vec_t mk(input int nreq, input logic [31:0] r0, r1, r2, r3, r4,
                              input logic [39:0] re, input int nrsp,
                              input logic [31:0] s0, s1, input logic wr, input logic [3:0] idx);
    vec_t v;
    v.nreq = 3'(nreq);
    v.rq[0] = r0; v.rq[1] = r1; v.rq[2] = r2; v.rq[3] = r3; v.rq[4] = r4;
    v.re = re;
    v.nrsp = 2'(nrsp);
    v.rs[0] = s0; v.rs[1] = s1;
    v.wr = wr;
    v.idx = idx;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    int bad = -1;
    for (int i = 0; i < N; i++) begin
      if ((bank[32*i +: 32] !== exp_regs[i]) && (bad < 0)) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s reg%0d actual=%08h required=%08h", name, bad, bank[32*bad +: 32], exp_regs[bad]);
    end
  endtask

  task automatic send_flit(input logic [31:0] d, input logic [7:0] e);
    bit done = 1'b0;
    req_ready = 1'b1; req_data = d; req_eofc = e;
    for (int n = 0; n < 40 && !done; n++) begin
      if (!req_stop) begin
        @(posedge clk); @(negedge clk); done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check32("req_accept_timeout", 32'd0, 32'd1);
    req_ready = 1'b0; req_data = 32'd0; req_eofc = 8'd0;
  endtask

  task automatic recv_flit(input string name, input logic [31:0] d, input logic [7:0] e);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (resp_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check32({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check32({name, "_data"}, resp_data, d);
      check32({name, "_eofc"}, {24'd0, resp_eofc}, {24'd0, e});
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    for (int i = 0; i < int'(v.nreq); i++) send_flit(v.rq[i], v.re[8*i +: 8]);
    check32({name, "_latency"}, {31'd0, resp_ready}, 32'd1);
    check32({name, "_busy"}, {31'd0, req_stop}, 32'd1);
    check32({name, "_strobe"}, {31'd0, wr_strobe}, {31'd0, v.wr});
    if (v.wr) begin
      check32({name, "_wr_index"}, {28'd0, wr_index}, {28'd0, v.idx});
      exp_regs[v.idx] = v.rq[2];
    end
    check_bank({name, "_bank"});
    for (int j = 0; j < int'(v.nrsp); j++)
      recv_flit($sformatf("%s_rsp%0d", name, j), v.rs[j], (j == int'(v.nrsp) - 1) ? 8'd4 : 8'd0);
    check32({name, "_no_extra"}, {31'd0, resp_ready}, 32'd0);
    check32({name, "_strobe_pulse"}, {31'd0, wr_strobe}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check32({name, "_stop"}, {31'd0, req_stop}, 32'd0);
    check32({name, "_resp"}, {23'd0, resp_ready, resp_eofc}, 32'd0);
    check32({name, "_resp_data"}, resp_data, 32'd0);
    check32({name, "_wr"}, {27'd0, wr_strobe, wr_index}, 32'd0);
    check_bank({name, "_bank"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    srst = 1'b1; req_ready = 1'b0; req_eofc = 8'd0; req_data = 32'd0; resp_stop = 1'b0;
    for (int i = 0; i < N; i++) exp_regs[i] = 32'd0;

    vecs[0]  = mk(3, 32'h00ABCD02, 32'h08, 32'hDEADBEEF, 32'h0, 32'h0, 40'h0000040000, 1, 32'h00ABCD00, 32'h0, 1'b1, 4'd2);
    vecs[1]  = mk(2, 32'h04000001, 32'h08, 32'h0, 32'h0, 32'h0, 40'h0000000400, 2, 32'h04000000, 32'hDEADBEEF, 1'b0, 4'd0);
    vecs[2]  = mk(2, 32'h11223301, 32'h40, 32'h0, 32'h0, 32'h0, 40'h0000000400, 1, 32'h11223301, 32'h0, 1'b0, 4'd0);
    vecs[3]  = mk(5, 32'h00555507, 32'h04, 32'h1, 32'h2, 32'h3, 40'h0400000000, 1, 32'h00555501, 32'h0, 1'b0, 4'd0);
    vecs[4]  = mk(2, 32'h00000101, 32'h08, 32'h0, 32'h0, 32'h0, 40'h0000000400, 2, 32'h00000100, 32'hDEADBEEF, 1'b0, 4'd0);
    vecs[5]  = mk(3, 32'h00777702, 32'h0A, 32'h12345678, 32'h0, 32'h0, 40'h0000040000, 1, 32'h00777701, 32'h0, 1'b0, 4'd0);
    vecs[6]  = mk(3, 32'h00888802, 32'h3C, 32'hCAFEF00D, 32'h0, 32'h0, 40'h0000040000, 1, 32'h00888800, 32'h0, 1'b1, 4'd15);
    vecs[7]  = mk(2, 32'h00999901, 32'h3C, 32'h0, 32'h0, 32'h0, 40'h0000000400, 2, 32'h00999900, 32'hCAFEF00D, 1'b0, 4'd0);
    vecs[8]  = mk(1, 32'h00AAAA01, 32'h0, 32'h0, 32'h0, 32'h0, 40'h0000000004, 1, 32'h00AAAA01, 32'h0, 1'b0, 4'd0);
    vecs[9]  = mk(3, 32'h00BBBB01, 32'h08, 32'h0, 32'h0, 32'h0, 40'h0000040000, 1, 32'h00BBBB01, 32'h0, 1'b0, 4'd0);
    vecs[10] = mk(4, 32'h00CCCC02, 32'h00, 32'h11111111, 32'h2222, 32'h0, 40'h0004000000, 1, 32'h00CCCC01, 32'h0, 1'b0, 4'd0);
    vecs[11] = mk(3, 32'h00DDDD02, 32'h04, 32'h5555, 32'h0, 32'h0, 40'h0000020000, 1, 32'h00DDDD01, 32'h0, 1'b0, 4'd0);
    vecs[12] = mk(2, 32'h00EEEE02, 32'h04, 32'h0, 32'h0, 32'h0, 40'h0000000400, 1, 32'h00EEEE01, 32'h0, 1'b0, 4'd0);
    vecs[13] = mk(3, 32'h00121202, 32'h00, 32'hA5A5A5A5, 32'h0, 32'h0, 40'h0000040000, 1, 32'h00121200, 32'h0, 1'b1, 4'd0);
    vecs[14] = mk(2, 32'h00343401, 32'h00, 32'h0, 32'h0, 32'h0, 40'h0000000200, 1, 32'h00343401, 32'h0, 1'b0, 4'd0);

    @(negedge clk);
    check32("rst_stop", {31'd0, req_stop}, 32'd1);
    @(negedge clk);
    srst = 1'b0;
    #1;
    check_reset_outputs("rst");

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Read response held off by the sink for ten cycles
    resp_stop = 1'b1;
    send_flit(32'h00004201, 8'd0);
    send_flit(32'h00000008, 8'd4);
    for (int k = 0; k < 10; k++) begin
      check32($sformatf("stall%0d_data", k), resp_data, 32'h00004200);
      check32($sformatf("stall%0d_ctl", k), {22'd0, req_stop, resp_ready, resp_eofc}, {22'd0, 1'b1, 1'b1, 8'd0});
      @(negedge clk);
    end
    resp_stop = 1'b0;
    recv_flit("stall_hdr", 32'h00004200, 8'd0);
    recv_flit("stall_dat", exp_regs[2], 8'd4);
    check32("stall_no_extra", {31'd0, resp_ready}, 32'd0);

    // Reset lands while a write frame waits for its data flit
    send_flit(32'h00F0F002, 8'd0);
    send_flit(32'h00000004, 8'd0);
    srst = 1'b1;
    #1;
    check32("srst_stop", {31'd0, req_stop}, 32'd1);
    @(posedge clk); @(negedge clk);
    srst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) exp_regs[i] = 32'd0;
    check_reset_outputs("srst");
    run_vec(mk(3, 32'h00F0F002, 32'h04, 32'h13572468, 32'h0, 32'h0, 40'h0000040000, 1, 32'h00F0F000, 32'h0, 1'b1, 4'd1), "post_w");
    run_vec(mk(2, 32'h00F0F101, 32'h04, 32'h0, 32'h0, 32'h0, 40'h0000000400, 2, 32'h00F0F100, 32'h13572468, 1'b0, 4'd0), "post_r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
